// File: rtl/mspu_ctrl_pkg.sv
// Shared types and constants for the pipeline control slice.
package mspu_ctrl_pkg;

  // Sequencer states: normal issue, frozen on data memory, squashing after redirect
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_t;

  // addi x0, x0, 0 -- what the stage registers load on a bubble or flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction in ID cannot be covered by forwarding and needs one bubble.
module hazard_detect (
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  input  logic [4:0] rd_ex,
  input  logic       reg_we_ex,
  input  logic       dmem_re_ex,
  output logic       load_use
);

  logic [4:0] rs_id   [2];
  logic [1:0] rs_used;
  logic [1:0] src_hit;

  assign rs_id[0]   = rs1_id;
  assign rs_id[1]   = rs2_id;
  assign rs_used[0] = rs1_used_id;
  assign rs_used[1] = rs2_used_id;

  // One comparator per source operand
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = rs_used[gi] && (rs_id[gi] == rd_ex);
  end

  // x0 is never a real dependency
  assign load_use = dmem_re_ex && reg_we_ex && (rd_ex != 5'd0) && (|src_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: memory-wait freeze with watchdog, branch
// redirect with IF/ID squash, load-use bubble insertion, perf counters.
module pipeline_ctrl
  import mspu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        rs1_used_id,
  input  logic        rs2_used_id,
  input  logic [4:0]  rd_ex,
  input  logic        reg_we_ex,
  input  logic        dmem_re_ex,
  input  logic        branch_taken_ex,
  input  logic [31:0] branch_target_ex,
  input  logic        dmem_req_ma,
  input  logic        dmem_ready,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_ma,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);
  localparam logic [1:0]  FLUSH_VAL   = 2'(FLUSH_CYCLES);

  ctrl_state_t state_reg, state_next;
  logic [15:0] wait_cnt_reg, wait_cnt_next;
  logic [1:0]  flush_cnt_reg, flush_cnt_next;
  logic        mem_err_reg, mem_err_next;
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_count_reg;

  logic load_use;
  logic mem_wait;
  logic stall_all;
  logic redirect;

  hazard_detect u_hazard (
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .rs1_used_id (rs1_used_id),
    .rs2_used_id (rs2_used_id),
    .rd_ex       (rd_ex),
    .reg_we_ex   (reg_we_ex),
    .dmem_re_ex  (dmem_re_ex),
    .load_use    (load_use)
  );

  assign mem_wait = dmem_req_ma && !dmem_ready;

  // Next-state and zero-latency control outputs; priority is mem wait > redirect > load-use
  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    mem_err_next   = mem_err_reg;
    stall_all      = 1'b0;
    redirect       = 1'b0;
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    bubble_ex      = 1'b0;
    flush_id       = 1'b0;
    unique case (state_reg)
      RUN: begin
        if (mem_wait) begin
          stall_all     = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = 16'd1;
        end else if (branch_taken_ex) begin
          // ID instruction is wrong-path, so any load-use on it is moot
          redirect       = 1'b1;
          flush_id       = 1'b1;
          bubble_ex      = 1'b1;
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_VAL;
        end else if (load_use) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_next    = RUN;
          wait_cnt_next = 16'd0;
        end else if (wait_cnt_reg >= TIMEOUT_VAL) begin
          // Watchdog: let the pipeline move on and leave a sticky error
          mem_err_next  = 1'b1;
          state_next    = RUN;
          wait_cnt_next = 16'd0;
        end else begin
          stall_all     = 1'b1;
          wait_cnt_next = wait_cnt_reg + 16'd1;
        end
      end
      FLUSH: begin
        if (mem_wait) begin
          // Frozen IF/ID already holds a NOP, so the remaining squash is dropped
          stall_all      = 1'b1;
          state_next     = MEM_WAIT;
          wait_cnt_next  = 16'd1;
          flush_cnt_next = 2'd0;
        end else begin
          flush_id       = 1'b1;
          flush_cnt_next = flush_cnt_reg - 2'd1;
          if (flush_cnt_reg <= 2'd1) begin
            state_next = RUN;
          end
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
    if (stall_all) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
    end
  end

  assign stall_ex     = stall_all;
  assign stall_ma     = stall_all;
  assign pc_load      = redirect;
  assign pc_next      = redirect ? branch_target_ex : 32'd0;
  assign mem_err      = mem_err_reg;
  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;

  // State, wait/flush counters, sticky error and performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= RUN;
      wait_cnt_reg     <= 16'd0;
      flush_cnt_reg    <= 2'd0;
      mem_err_reg      <= 1'b0;
      stall_cycles_reg <= 32'd0;
      flush_count_reg  <= 32'd0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
      mem_err_reg   <= mem_err_next;
      if (stall_if) begin
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
      if (redirect) begin
        flush_count_reg <= flush_count_reg + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic against a cycle-level reference model of the stall/flush rules.
module tb_pipeline_ctrl;

  localparam int T  = 4;   // watchdog limit
  localparam int FC = 2;   // extra squash cycles after a redirect

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_id, rs2_id, rd_ex;
  logic        rs1_used_id, rs2_used_id, reg_we_ex, dmem_re_ex;
  logic        branch_taken_ex, dmem_req_ma, dmem_ready;
  logic [31:0] branch_target_ex;
  logic        stall_if, stall_id, stall_ex, stall_ma, bubble_ex, flush_id, pc_load, mem_err;
  logic [31:0] pc_next, stall_cycles, flush_count;

  pipeline_ctrl #(.MEM_TIMEOUT(T), .FLUSH_CYCLES(FC)) dut (
    .clk              (clk),
    .reset            (reset),
    .rs1_id           (rs1_id),
    .rs2_id           (rs2_id),
    .rs1_used_id      (rs1_used_id),
    .rs2_used_id      (rs2_used_id),
    .rd_ex            (rd_ex),
    .reg_we_ex        (reg_we_ex),
    .dmem_re_ex       (dmem_re_ex),
    .branch_taken_ex  (branch_taken_ex),
    .branch_target_ex (branch_target_ex),
    .dmem_req_ma      (dmem_req_ma),
    .dmem_ready       (dmem_ready),
    .stall_if         (stall_if),
    .stall_id         (stall_id),
    .stall_ex         (stall_ex),
    .stall_ma         (stall_ma),
    .bubble_ex        (bubble_ex),
    .flush_id         (flush_id),
    .pc_load          (pc_load),
    .pc_next          (pc_next),
    .mem_err          (mem_err),
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
  );

  always #5 clk = ~clk;

  // {stalls[4], bubble, flush, pc_load, pc_next, mem_err, stall_cycles, flush_count}
  logic [103:0] act_vec, exp_vec;
  assign act_vec = {stall_if, stall_id, stall_ex, stall_ma, bubble_ex, flush_id, pc_load,
                    pc_next, mem_err, stall_cycles, flush_count};

  int tests = 0;
  int fails = 0;

  // Reference model: cycles waited on memory so far (0 = not waiting),
  // squash slots still owed, and the observable counters.
  int          m_waited, m_squash, n_waited, n_squash;
  logic        m_err, n_err;
  logic [31:0] m_sc, m_fc, n_sc, n_fc;

  task automatic model_reset();
    m_waited = 0; m_squash = 0; m_err = 1'b0; m_sc = 32'd0; m_fc = 32'd0;
  endtask

  // Apply one cycle of inputs, predict outputs for this cycle and model state for the next
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic we, input logic re, input logic br,
                       input logic [31:0] tgt, input logic req, input logic rdy);
    logic freeze, sif, sid, bub, fid, pcl, lu;
    rs1_id = rs1; rs2_id = rs2; rs1_used_id = u1; rs2_used_id = u2;
    rd_ex = rd; reg_we_ex = we; dmem_re_ex = re; branch_taken_ex = br;
    branch_target_ex = tgt; dmem_req_ma = req; dmem_ready = rdy;
    freeze = 0; sif = 0; sid = 0; bub = 0; fid = 0; pcl = 0;
    n_waited = m_waited; n_squash = m_squash; n_err = m_err; n_fc = m_fc;
    lu = re && we && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    if (m_waited > 0) begin
      if (rdy) n_waited = 0;
      else if (m_waited >= T) begin n_waited = 0; n_err = 1'b1; end
      else begin freeze = 1; n_waited = m_waited + 1; end
    end else if (req && !rdy) begin
      freeze = 1; n_waited = 1; n_squash = 0;
    end else if (m_squash > 0) begin
      fid = 1; n_squash = m_squash - 1;
    end else if (br) begin
      pcl = 1; fid = 1; bub = 1; n_squash = FC; n_fc = m_fc + 1;
    end else if (lu) begin
      sif = 1; sid = 1; bub = 1;
    end
    if (freeze) begin sif = 1; sid = 1; end
    n_sc = m_sc + (sif ? 32'd1 : 32'd0);
    exp_vec = {sif, sid, freeze, freeze, bub, fid, pcl, (pcl ? tgt : 32'd0), m_err, m_sc, m_fc};
    #1;
    $display("[TB] t=%0t req=%b rdy=%b br=%b lu=%b -> stall=%b%b%b%b bub=%b flush=%b pcl=%b pc=%h err=%b sc=%0d fc=%0d",
             $time, req, rdy, br, lu, stall_if, stall_id, stall_ex, stall_ma, bubble_ex, flush_id,
             pc_load, pc_next, mem_err, stall_cycles, flush_count);
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // Advance through the clock edge, commit the model, return at the falling edge
  task automatic step();
    @(posedge clk);
    m_waited = n_waited; m_squash = n_squash; m_err = n_err; m_sc = n_sc; m_fc = n_fc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    #2;
    model_reset();
    tests++;
    if (act_vec !== 104'd0) begin
      fails++; $display("FAIL reset_hold: got %h expected %h", act_vec, 104'd0);
    end
    do_reset();
    idle();
    tests++;
    if (act_vec !== exp_vec) begin
      fails++; $display("FAIL reset_idle: got %h expected %h", act_vec, exp_vec);
    end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(5'd5, 5'd9, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    tests++;
    if (act_vec !== exp_vec || {stall_if, stall_id, bubble_ex, stall_ex} !== 4'b1110) begin
      fails++; $display("FAIL load_use_rd5: got %h expected %h", act_vec, exp_vec);
    end
    step();
    idle();
    tests++;
    if (act_vec !== exp_vec || stall_if !== 1'b0) begin
      fails++; $display("FAIL load_use_one_cycle: got %h expected %h", act_vec, exp_vec);
    end
    step();
    drive(5'd0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    tests++;
    if (act_vec !== exp_vec || stall_if !== 1'b0) begin
      fails++; $display("FAIL load_use_rd0: got %h expected %h", act_vec, exp_vec);
    end
    step();
    drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    tests++;
    if (act_vec !== exp_vec) begin
      fails++; $display("FAIL load_use_rs2: got %h expected %h", act_vec, exp_vec);
    end
    step();
  endtask

  task automatic test_branch();
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    tests++;
    if (act_vec !== exp_vec || pc_load !== 1'b1 || pc_next !== 32'h100) begin
      fails++; $display("FAIL branch_redirect: got %h expected %h", act_vec, exp_vec);
    end
    step();
    for (int i = 0; i < FC + 1; i++) begin
      idle();
      tests++;
      if (act_vec !== exp_vec || flush_id !== (i < FC)) begin
        fails++; $display("FAIL branch_squash_%0d: got %h expected %h", i, act_vec, exp_vec);
      end
      step();
    end
    idle();
    tests++;
    if (flush_count !== 32'd1) begin
      fails++; $display("FAIL branch_flush_count: got %0d expected 1", flush_count);
    end
    step();
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      tests++;
      if (act_vec !== exp_vec || {stall_if, stall_id, stall_ex, stall_ma} !== 4'hf) begin
        fails++; $display("FAIL mem_wait_stall_%0d: got %h expected %h", i, act_vec, exp_vec);
      end
      step();
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    tests++;
    if (act_vec !== exp_vec || stall_ma !== 1'b0) begin
      fails++; $display("FAIL mem_wait_release: got %h expected %h", act_vec, exp_vec);
    end
    step();
    idle();
    tests++;
    if (stall_cycles !== 32'd3) begin
      fails++; $display("FAIL mem_wait_stall_cycles: got %0d expected 3", stall_cycles);
    end
    step();
  endtask

  task automatic test_priority();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, (i == 2));
      tests++;
      if (act_vec !== exp_vec || pc_load !== 1'b0) begin
        fails++; $display("FAIL priority_mem_first_%0d: got %h expected %h", i, act_vec, exp_vec);
      end
      step();
    end
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
    tests++;
    if (act_vec !== exp_vec || pc_load !== 1'b1 || pc_next !== 32'h200 || stall_if !== 1'b0) begin
      fails++; $display("FAIL priority_branch_after: got %h expected %h", act_vec, exp_vec);
    end
    step();
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < T + 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      tests++;
      if (act_vec !== exp_vec || stall_if !== (i != T)) begin
        fails++; $display("FAIL watchdog_cycle_%0d: got %h expected %h", i, act_vec, exp_vec);
      end
      step();
    end
    do_reset();
    idle();
    tests++;
    if (mem_err !== 1'b0) begin
      fails++; $display("FAIL watchdog_reset_clear: got %b expected 0", mem_err);
    end
    step();
  endtask

  task automatic test_watchdog_sticky();
    do_reset();
    for (int i = 0; i < T + 1; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      tests++;
      if (act_vec !== exp_vec || mem_err !== 1'b1) begin
        fails++; $display("FAIL watchdog_sticky_%0d: got %h expected %h", i, act_vec, exp_vec);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0440, 1'b0, 1'b0);
    step();
    idle();
    tests++;
    if (act_vec !== exp_vec || flush_id !== 1'b1) begin
      fails++; $display("FAIL async_pre_flush: got %h expected %h", act_vec, exp_vec);
    end
    reset = 1'b1;
    #1;
    model_reset();
    tests++;
    if (act_vec !== 104'd0) begin
      fails++; $display("FAIL async_reset_now: got %h expected %h", act_vec, 104'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
    tests++;
    if (act_vec !== exp_vec || flush_id !== 1'b0) begin
      fails++; $display("FAIL async_no_stale_flush: got %h expected %h", act_vec, exp_vec);
    end
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 99) < 15), $urandom,
            ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 45));
      tests++;
      if (act_vec !== exp_vec) begin
        fails++; $display("FAIL random_%0d: got %h expected %h", i, act_vec, exp_vec);
      end
      step();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_priority();
    test_watchdog();
    test_watchdog_sticky();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage core. It detects load-use hazards that the operand-forwarding network cannot cover and inserts bubbles for them. It redirects the PC and squashes wrong-path instructions on taken branches. It freezes the whole pipeline while a data-memory access in MA waits for `dmem_ready`, with a watchdog and performance counters. It sits beside the forwarding unit and drives the enable/flush inputs of the IF/ID, ID/EX, EX/MA and MA/WB pipeline registers.

## Interface
- `MEM_TIMEOUT`, default 255: maximum MEM_WAIT cycles before forced release (range 1..65535).
- `FLUSH_CYCLES`, default 1: extra cycles for which IF/ID is squashed after a redirect (covers imem latency; range 1..3).

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `rs1_id`, `rs2_id`  in  5  source registers of the instruction in ID.
- `rs1_used_id`, `rs2_used_id`  in  1  the ID instruction actually reads rs1/rs2.
- `rd_ex`  in  5  destination register in EX.
- `reg_we_ex`  in  1  EX instruction writes a register.
- `dmem_re_ex`  in  1  EX instruction is a load.
- `branch_taken_ex`  in  1  EX resolved a taken branch/jump.
- `branch_target_ex`  in  32  redirect address.
- `dmem_req_ma`  in  1  MA instruction is issuing a load/store.
- `dmem_ready`  in  1  data memory completes the MA access this cycle.
- `stall_if`, `stall_id`, `stall_ex`, `stall_ma`  out  1  hold the corresponding stage register.
- `bubble_ex`  out  1  load a NOP into ID/EX.
- `flush_id`  out  1  load a NOP into IF/ID.
- `pc_load`  out  1  load `pc_next` into the PC.
- `pc_next`  out  32  redirect target.
- `mem_err`  out  1  sticky flag: watchdog fired.
- `stall_cycles`, `flush_count`  out  32  performance counters.

## Operation
- States: RUN, MEM_WAIT, FLUSH. Held in a registered state machine.
- Outputs are combinational from the current state and the inputs. Counters and `mem_err` are registered.
- Per-cycle priority: memory wait > branch redirect > load-use.

RUN state:
- Memory wait: `dmem_req_ma && !dmem_ready`.
  - Assert all four stalls.
  - Next state MEM_WAIT; wait counter is set to 1.
- Taken branch: `branch_taken_ex` (no memory wait this cycle).
  - Assert `pc_load`, `pc_next=branch_target_ex`, `flush_id`, `bubble_ex`.
  - Next state FLUSH; flush counter is set to FLUSH_CYCLES.
  - `flush_count` increments.
  - A simultaneous load-use hazard is ignored, because the ID instruction is squashed.
- Load-use: `dmem_re_ex && reg_we_ex && rd_ex!=0 && ((rs1_used_id && rd_ex==rs1_id) || (rs2_used_id && rd_ex==rs2_id))`.
  - Assert `stall_if`, `stall_id`, `bubble_ex` for exactly that cycle.
  - Stay in RUN; next cycle the load is in MA and forwarding resolves it.

MEM_WAIT state:
- Assert all four stalls until the cycle in which `dmem_ready=1`.
- That release cycle has no stalls; next state is RUN.
- The wait counter increments on every cycle without ready.
- If the counter reaches MEM_TIMEOUT: set `mem_err`, release as if ready, return to RUN.
- A taken branch held in EX is acted on only after release, when it is re-presented in RUN.

FLUSH state:
- Assert `flush_id` and decrement the flush counter.
- Return to RUN when the counter reaches 0.
- A new memory wait arriving in FLUSH takes priority: go to MEM_WAIT and drop the remaining flush cycles, because the stalled IF/ID still holds a squashed NOP.
- A new `branch_taken_ex` in FLUSH is ignored, because EX holds a bubble.

Counters:
- `stall_cycles` increments on any cycle with `stall_if=1`.
- Both counters wrap modulo 2^32.
- `mem_err` clears only on reset.

## Timing
- Reset (async) values:
  - state=RUN; wait/flush counters = 0; `mem_err=0`; `stall_cycles=0`; `flush_count=0`.
  - With inputs idle, all stall/flush/bubble outputs = 0; `pc_load=0`; `pc_next=0`.
- Hazard and stall outputs have zero-cycle latency: they are asserted in the same cycle as the triggering input.
- Load-use costs exactly 1 bubble.
- Taken branch costs 1+FLUSH_CYCLES squashed slots.
- A memory wait of N not-ready cycles costs N stall cycles.
- Reset asserted mid-MEM_WAIT or mid-FLUSH forces RUN immediately. No stale flush survives reset.

## Structure
- Package `mspu_ctrl_pkg`: state enum `ctrl_state_t` {RUN, MEM_WAIT, FLUSH} and a NOP encoding constant (32'h00000013) used by the stage registers.
- Sub-module `hazard_detect`: combinational load-use compare, reused by future issue logic. All state, counters and the watchdog stay in `pipeline_ctrl`.

## Test plan
- Load-use: `rd_ex=5`, load in EX, `rs1_id=5`, `rs1_used_id=1` → exactly one cycle of `stall_if=stall_id=bubble_ex=1`; the same pattern with `rd_ex=0` → no stall.
- Branch: `branch_taken_ex=1`, target 32'h0000_0100 → `pc_load=1`, `pc_next=32'h100`, `flush_id=1` that cycle plus FLUSH_CYCLES more; `flush_count=1`.
- Memory wait: `dmem_req_ma=1`, `dmem_ready` low for 3 cycles then high → all stalls high for 3 cycles, low on the ready cycle; `stall_cycles=3`.
- Priority: memory wait plus branch plus load-use in the same cycle → only the memory stall; the branch redirect occurs in the first RUN cycle after ready.
- Watchdog: MEM_TIMEOUT=4, `dmem_ready` never asserted → release after 4 cycles, `mem_err=1` and sticky.
- Async reset asserted during FLUSH → outputs return to 0 and state to RUN immediately without waiting for `clk`; counters = 0.
